// File: rtl/data_bank.sv
// Dual-read-port operand bank for the Kalman datapath. A hardware CLEAR
// sequence zeroes every word after reset or a soft clear before writes are accepted.
module data_bank #(
    parameter int W     = 24,
    parameter int ADDRW = 5,
    parameter int DEPTH = 2**ADDRW
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [W-1:0]     db_data,
    input  logic [ADDRW-1:0] db_dira,
    input  logic [ADDRW-1:0] db_dirb,
    input  logic             db_write,
    input  logic             CLR_REQ,
    output logic [W-1:0]     DATA_A,
    output logic [W-1:0]     DATA_B,
    output logic             VALID,
    output logic             READY,
    output logic             DROP
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [ADDRW-1:0] LAST_PTR = ADDRW'(DEPTH - 1);

    state_e           state_q;
    logic [ADDRW-1:0] ptr_q;
    logic [W-1:0]     data_a_q;
    logic [W-1:0]     data_b_q;
    logic             valid_q;
    logic             ready_q;
    logic             drop_q;

    logic [W-1:0]     mem [DEPTH];

    logic             run;
    logic             wr_en;
    logic             mem_we;
    logic [ADDRW-1:0] mem_waddr;
    logic [W-1:0]     mem_wdata;
    logic [W-1:0]     data_a_d;
    logic [W-1:0]     data_b_d;

    // The single memory write port is shared: CLEAR owns it, otherwise the user write.
    always_comb begin
        run       = (state_q == ST_RUN);
        wr_en     = run && db_write;
        mem_we    = RST_N && (wr_en || !run);
        mem_waddr = run ? db_dira : ptr_q;
        mem_wdata = run ? db_data : '0;
        data_a_d  = wr_en ? db_data : mem[db_dira];
        data_b_d  = (wr_en && (db_dirb == db_dira)) ? db_data : mem[db_dirb];
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    data_a_q <= '0;
                    data_b_q <= '0;
                    valid_q  <= 1'b0;
                    if (db_write) begin
                        drop_q <= 1'b1;
                    end
                    if (ptr_q == LAST_PTR) begin
                        ptr_q   <= '0;
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    data_a_q <= data_a_d;
                    data_b_q <= data_b_d;
                    valid_q  <= 1'b1;
                    if (CLR_REQ) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign DATA_A = data_a_q;
    assign DATA_B = data_b_q;
    assign VALID  = valid_q;
    assign READY  = ready_q;
    assign DROP   = drop_q;

endmodule

// File: tb/tb_data_bank.sv
// Self-checking bench for data_bank: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural bank model.
module tb_data_bank;

    localparam int W     = 24;
    localparam int ADDRW = 5;
    localparam int DEPTH = 32;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     db_data;
    logic [ADDRW-1:0] db_dira;
    logic [ADDRW-1:0] db_dirb;
    logic             db_write;
    logic             clr_req;
    logic [W-1:0]     data_a;
    logic [W-1:0]     data_b;
    logic             valid;
    logic             ready;
    logic             drop;

    int n_checks = 0;
    int n_fail   = 0;

    data_bank #(.W(W), .ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .db_data  (db_data),
        .db_dira  (db_dira),
        .db_dirb  (db_dirb),
        .db_write (db_write),
        .CLR_REQ  (clr_req),
        .DATA_A   (data_a),
        .DATA_B   (data_b),
        .VALID    (valid),
        .READY    (ready),
        .DROP     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: word array plus "edges of clearing still owed".
    logic [W-1:0] m_mem [DEPTH];
    int           m_clear_left;
    logic [W-1:0] m_a, m_b;
    logic         m_valid, m_drop;
    bit           m_init = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init       = 1;
            m_clear_left = DEPTH;
            m_a          = '0;
            m_b          = '0;
            m_valid      = 0;
            m_drop       = 0;
        end else if (m_init) begin
            if (m_clear_left == 0) begin
                m_a     = db_write ? db_data : m_mem[db_dira];
                m_b     = (db_write && db_dirb == db_dira) ? db_data : m_mem[db_dirb];
                m_valid = 1;
                if (db_write) m_mem[db_dira] = db_data;
                if (clr_req) m_clear_left = DEPTH;
            end else begin
                m_a     = '0;
                m_b     = '0;
                m_valid = 0;
                if (db_write) m_drop = 1;
                m_mem[DEPTH - m_clear_left] = '0;
                m_clear_left--;
            end
        end
        #1;
        if (m_init) begin
            chk("model_DATA_A", 32'(data_a), 32'(m_a));
            chk("model_DATA_B", 32'(data_b), 32'(m_b));
            chk("model_VALID",  32'(valid),  32'(m_valid));
            chk("model_READY",  32'(ready),  32'(m_clear_left == 0));
            chk("model_DROP",   32'(drop),   32'(m_drop));
        end
    end

    task automatic step(input logic rst, input logic wr, input logic [W-1:0] d,
                        input logic [ADDRW-1:0] a, input logic [ADDRW-1:0] b, input logic clr);
        @(negedge clk);
        rst_n    = rst;
        db_write = wr;
        db_data  = d;
        db_dira  = a;
        db_dirb  = b;
        clr_req  = clr;
        @(posedge clk);
        #2;
        $display("txn t=%0t rst_n=%b wr=%b d=%h a=%h b=%h clr=%b -> A=%h B=%h V=%b R=%b D=%b",
                 $time, rst, wr, d, a, b, clr, data_a, data_b, valid, ready, drop);
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        rst_n = 0; db_write = 0; db_data = '0; db_dira = '0; db_dirb = '0; clr_req = 0;

        // T1: reset, READY low for exactly DEPTH edges, then bank reads zero.
        idle(1'b0);
        idle(1'b0);
        chk("rst_READY", 32'(ready), 32'd0);
        chk("rst_VALID", 32'(valid), 32'd0);
        chk("rst_DROP",  32'(drop),  32'd0);
        chk("rst_DATA_A", 32'(data_a), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            idle(1'b1);
            chk("t1_READY_timing", 32'(ready), 32'(i == DEPTH));
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, '0, 5'(i), 5'(DEPTH - 1 - i), 1'b0);
            chk("t1_sweep_A", 32'(data_a), 32'd0);
            chk("t1_sweep_B", 32'(data_b), 32'd0);
            chk("t1_sweep_VALID", 32'(valid), 32'd1);
        end

        // T2: write then read back.
        step(1'b1, 1'b1, 24'hC0FFEE, 5'h03, 5'h00, 1'b0);
        step(1'b1, 1'b0, '0, 5'h03, 5'h1C, 1'b0);
        chk("t2_A", 32'(data_a), 32'h00C0FFEE);
        chk("t2_B", 32'(data_b), 32'h00000000);

        // T3: write-first bypass on both ports.
        step(1'b1, 1'b1, 24'h123456, 5'h1C, 5'h1C, 1'b0);
        chk("t3_A", 32'(data_a), 32'h00123456);
        chk("t3_B", 32'(data_b), 32'h00123456);

        // T5 + T4: soft clear, dropped write during CLEAR.
        step(1'b1, 1'b1, 24'hC0FFEE, 5'h03, 5'h00, 1'b0);
        step(1'b1, 1'b0, '0, 5'h00, 5'h00, 1'b1);
        chk("t5_READY_low", 32'(ready), 32'd0);
        step(1'b1, 1'b1, 24'hABCDEF, 5'h12, 5'h12, 1'b0);
        chk("t4_DROP_set", 32'(drop), 32'd1);
        chk("t5_VALID_low", 32'(valid), 32'd0);
        for (int i = 2; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, '0, '0, '0, 1'b1);
            chk("t5_READY_timing", 32'(ready), 32'(i == DEPTH));
        end
        step(1'b1, 1'b0, '0, 5'h03, 5'h12, 1'b0);
        chk("t5_A_cleared", 32'(data_a), 32'd0);
        chk("t4_B_dropped", 32'(data_b), 32'd0);
        chk("t4_DROP_sticky", 32'(drop), 32'd1);

        // T6: reset while CLEAR has reached ptr=10.
        step(1'b1, 1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 10; i++) idle(1'b1);
        idle(1'b0);
        chk("t6_DROP_reset", 32'(drop), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            idle(1'b1);
            chk("t6_READY_timing", 32'(ready), 32'(i == DEPTH));
        end

        // Randomized traffic; the model checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [ADDRW-1:0] a, b;
            a = 5'($urandom_range(DEPTH - 1));
            b = ($urandom_range(3) == 0) ? a : 5'($urandom_range(DEPTH - 1));
            step(($urandom_range(399) != 0),
                 ($urandom_range(1) == 1),
                 24'($urandom),
                 a, b,
                 ($urandom_range(99) == 0));
        end

        idle(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
